ip_rx: RTL and testbench



---
 rtl/ip_pkg.sv | 20 ++
 rtl/ip_csum_check.sv | 33 +++
 rtl/ip_rx.sv | 179 +++++++++++++++++
 tb/tb_ip_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared IPv4 receive/transmit definitions: header constants and the receive FSM state type.
package ip_pkg;

    localparam int unsigned IP_HDR_LEN = 20;
    localparam int unsigned CSUM_ACC_W = 20;

    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
    localparam logic [31:0] IP_BCAST     = 32'hFFFF_FFFF;
    localparam logic [15:0] IP_CSUM_GOOD = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DROP
    } ip_state_t;

endpackage

// File: rtl/ip_csum_check.sv
// Byte-serial IPv4 one's-complement checksum accumulator; even bytes are the high half of each word.
module ip_csum_check
    import ip_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_sum_c,
    output logic        o_ok_c
);

    logic [CSUM_ACC_W-1:0] r_acc;
    logic                  r_odd;
    logic [16:0]           w_fold1;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
            r_odd <= 1'b0;
        end else if (i_en) begin
            r_acc <= r_acc + (r_odd ? CSUM_ACC_W'(i_data) : CSUM_ACC_W'({i_data, 8'h00}));
            r_odd <= ~r_odd;
        end
    end

    // Two folds: the first can leave a single carry, the second absorbs it.
    assign w_fold1 = 17'(r_acc[15:0]) + 17'(r_acc[CSUM_ACC_W-1:16]);
    assign o_sum_c = w_fold1[15:0] + 16'(w_fold1[16]);
    assign o_ok_c  = (o_sum_c == IP_CSUM_GOOD);

endmodule

// File: rtl/ip_rx.sv
// IPv4 receive stage: checks and strips the 20-byte header, forwards the payload two cycles behind the MAC.
module ip_rx
    import ip_pkg::*;
#(
    parameter logic [31:0] P_LOCAL_IP   = 32'hC0A8_0102,
    parameter logic [31:0] P_TARGET_IP  = 32'hC0A8_0103,
    parameter logic        P_SRC_FILTER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_local_ip,
    input  logic        i_local_ip_valid,
    input  logic [31:0] i_target_ip,
    input  logic        i_target_ip_valid,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_last,
    input  logic        i_mac_valid,
    output logic [7:0]  o_ip_data,
    output logic [15:0] o_ip_len,
    output logic        o_ip_last,
    output logic        o_ip_valid,
    output logic [7:0]  o_ip_protocol,
    output logic [31:0] o_ip_src_ip,
    output logic        o_ip_err,
    output logic [15:0] o_drop_cnt
);

    logic [31:0] r_local_ip;
    logic [31:0] r_target_ip;
    logic [15:0] r_cnt;
    logic [7:0]  r_ver;
    logic [15:0] r_tot_len;
    logic [15:0] r_frag;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [7:0]  r_s1_data;
    logic        r_s1_valid;
    logic        r_s1_last;
    logic [15:0] r_s1_idx;
    logic [15:0] r_last_idx;
    ip_state_t   r_state;

    logic [15:0] w_csum_sum;
    logic        w_csum_ok;
    logic        w_hdr_ok;
    logic        w_in_hdr;
    logic        w_hdr_end;
    logic        w_drop_inc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_local_ip  <= P_LOCAL_IP;
            r_target_ip <= P_TARGET_IP;
        end else begin
            if (i_local_ip_valid)  r_local_ip  <= i_local_ip;
            if (i_target_ip_valid) r_target_ip <= i_target_ip;
        end
    end

    // Header fields are captured straight off the MAC stream, one cycle ahead of the FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_ver     <= '0;
            r_tot_len <= '0;
            r_frag    <= '0;
            r_proto   <= '0;
            r_src     <= '0;
            r_dst     <= '0;
        end else if (i_mac_valid) begin
            if (i_mac_last)              r_cnt <= '0;
            else if (r_cnt != 16'hFFFF)  r_cnt <= r_cnt + 16'd1;
            case (r_cnt)
                16'd0:  r_ver           <= i_mac_data;
                16'd2:  r_tot_len[15:8] <= i_mac_data;
                16'd3:  r_tot_len[7:0]  <= i_mac_data;
                16'd6:  r_frag[15:8]    <= i_mac_data;
                16'd7:  r_frag[7:0]     <= i_mac_data;
                16'd9:  r_proto         <= i_mac_data;
                16'd12, 16'd13, 16'd14, 16'd15: r_src <= {r_src[23:0], i_mac_data};
                16'd16, 16'd17, 16'd18, 16'd19: r_dst <= {r_dst[23:0], i_mac_data};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= i_mac_valid;
            if (i_mac_valid) begin
                r_s1_data <= i_mac_data;
                r_s1_last <= i_mac_last;
                r_s1_idx  <= r_cnt;
            end
        end
    end

    ip_csum_check u_csum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_mac_valid && i_mac_last),
        .i_en   (i_mac_valid && (r_cnt < 16'(IP_HDR_LEN))),
        .i_data (i_mac_data),
        .o_sum_c(w_csum_sum),
        .o_ok_c (w_csum_ok)
    );

    assign w_hdr_ok = (r_ver == IPV4_VER_IHL)
                   && (r_tot_len >= 16'(IP_HDR_LEN))
                   && ((r_frag & 16'h3FFF) == 16'h0000)
                   && ((r_proto == IP_PROTO_UDP) || (r_proto == IP_PROTO_ICMP))
                   && ((r_dst == r_local_ip) || (r_dst == IP_BCAST))
                   && (!P_SRC_FILTER || (r_src == r_target_ip))
                   && w_csum_ok && (w_csum_sum == IP_CSUM_GOOD);

    assign w_in_hdr   = r_s1_valid && ((r_state == IDLE) || (r_state == HEADER));
    assign w_hdr_end  = w_in_hdr && (r_s1_idx == 16'(IP_HDR_LEN - 1));
    // An accepted empty packet ending on its last header byte is complete, not a drop.
    assign w_drop_inc = w_in_hdr && (w_hdr_end
                        ? (!w_hdr_ok || (r_s1_last && (r_tot_len != 16'(IP_HDR_LEN))))
                        : r_s1_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_last_idx    <= '0;
            o_ip_data     <= '0;
            o_ip_len      <= '0;
            o_ip_last     <= 1'b0;
            o_ip_valid    <= 1'b0;
            o_ip_protocol <= '0;
            o_ip_src_ip   <= '0;
            o_ip_err      <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            o_ip_valid <= 1'b0;
            o_ip_last  <= 1'b0;
            o_ip_err   <= 1'b0;
            if (w_drop_inc && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
            if (w_hdr_end && w_hdr_ok) begin
                o_ip_len      <= r_tot_len - 16'(IP_HDR_LEN);
                o_ip_protocol <= r_proto;
                o_ip_src_ip   <= r_src;
                r_last_idx    <= r_tot_len - 16'd1;
            end
            if (r_s1_valid) begin
                case (r_state)
                    IDLE, HEADER: begin
                        if (r_s1_last)
                            r_state <= IDLE;
                        else if (w_hdr_end)
                            r_state <= (w_hdr_ok && (r_tot_len != 16'(IP_HDR_LEN))) ? PAYLOAD : DROP;
                        else
                            r_state <= HEADER;
                    end
                    PAYLOAD: begin
                        o_ip_valid <= 1'b1;
                        o_ip_data  <= r_s1_data;
                        o_ip_last  <= r_s1_last || (r_s1_idx == r_last_idx);
                        o_ip_err   <= r_s1_last && (r_s1_idx != r_last_idx);
                        if (r_s1_last)                    r_state <= IDLE;
                        else if (r_s1_idx == r_last_idx)  r_state <= DROP;
                    end
                    DROP: begin
                        if (r_s1_last) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ip_rx.sv
// Directed self-checking bench for ip_rx: acceptance, padding, filtering, truncation, gaps and reset.
module tb_ip_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] local_ip;
    logic        local_ip_valid;
    logic [31:0] target_ip;
    logic        target_ip_valid;
    logic [7:0]  mac_data;
    logic        mac_last;
    logic        mac_valid;
    logic [7:0]  ip_data;
    logic [15:0] ip_len;
    logic        ip_last;
    logic        ip_valid;
    logic [7:0]  ip_protocol;
    logic [31:0] ip_src_ip;
    logic        ip_err;
    logic [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] tx[$];
    logic [7:0] out_q[$];
    int         out_cyc[$];
    int         in_cyc[$];
    int         last_pos[$];
    int         err_cnt;
    int         err_at;

    ip_rx dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_local_ip       (local_ip),
        .i_local_ip_valid (local_ip_valid),
        .i_target_ip      (target_ip),
        .i_target_ip_valid(target_ip_valid),
        .i_mac_data       (mac_data),
        .i_mac_last       (mac_last),
        .i_mac_valid      (mac_valid),
        .o_ip_data        (ip_data),
        .o_ip_len         (ip_len),
        .o_ip_last        (ip_last),
        .o_ip_valid       (ip_valid),
        .o_ip_protocol    (ip_protocol),
        .o_ip_src_ip      (ip_src_ip),
        .o_ip_err         (ip_err),
        .o_drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ip_valid) begin
            out_q.push_back(ip_data);
            out_cyc.push_back(cyc);
            if (ip_last) last_pos.push_back(out_q.size() - 1);
        end
        if (ip_err) begin
            err_cnt = err_cnt + 1;
            err_at  = out_q.size() - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] csum(input logic [7:0] h [20]);
        int unsigned s = 0;
        for (int i = 0; i < 20; i += 2) s = s + 32'({h[i], h[i+1]});
        while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
        return ~(16'(s));
    endfunction

    function automatic logic [7:0] pay(input int pat, input int i);
        return (pat == 0) ? 8'(8'hA0 + i) : 8'(i * 3);
    endfunction

    task automatic mk_frame(input logic [15:0] tl, input logic [31:0] dst, input int n_pay,
                            input int n_pad, input int pat, input logic corrupt);
        logic [7:0]  h [20];
        logic [15:0] cs;
        logic [31:0] src;
        src = 32'hC0A8_0103;
        h[0] = 8'h45; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
        h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h00; h[7] = 8'h00;
        h[8] = 8'h40; h[9] = 8'd17; h[10] = 8'h00; h[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[12+i] = src[31-8*i -: 8];
            h[16+i] = dst[31-8*i -: 8];
        end
        cs = csum(h);
        h[10] = cs[15:8];
        h[11] = cs[7:0] ^ {7'd0, corrupt};
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(h[i]);
        for (int i = 0; i < n_pay; i++) tx.push_back(pay(pat, i));
        for (int i = 0; i < n_pad; i++) tx.push_back(8'h00);
    endtask

    task automatic send_tx(input int n, input int gaps, input logic with_last);
        for (int i = 0; i < n; i++) begin
            if (gaps != 0 && (i % 2) == 1) begin
                mac_valid = 1'b0;
                mac_last  = 1'b0;
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            mac_data  = tx[i];
            mac_valid = 1'b1;
            mac_last  = with_last && (i == n - 1);
            in_cyc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        mac_valid = 1'b0;
        mac_last  = 1'b0;
    endtask

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        last_pos.delete();
        err_cnt = 0;
        err_at  = -1;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic int bad_bytes(input int n, input int pat);
        int b = 0;
        for (int i = 0; i < n && i < out_q.size(); i++)
            if (out_q[i] !== pay(pat, i)) b++;
        return b;
    endfunction

    function automatic int lat_bad();
        int b = 0;
        for (int k = 0; k < out_q.size(); k++)
            if ((20 + k) >= in_cyc.size() || (out_cyc[k] - in_cyc[20+k]) != 2) b++;
        return b;
    endfunction

    function automatic int first_last();
        return (last_pos.size() > 0) ? last_pos[0] : -1;
    endfunction

    initial begin
        rst = 1'b1; local_ip = '0; local_ip_valid = 1'b0;
        target_ip = 32'h0A00_0001; target_ip_valid = 1'b0;
        mac_data = '0; mac_last = 1'b0; mac_valid = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(ip_valid), 32'd0);
        check("rst_len",   32'(ip_len), 32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        check("rst_src",   ip_src_ip, 32'd0);

        // Valid UDP, 16-byte payload, no padding
        clear_mon();
        mk_frame(16'd36, 32'hC0A8_0102, 16, 0, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t1_count", 32'(out_q.size()), 32'd16);
        check("t1_data",  32'(bad_bytes(16, 0)), 32'd0);
        check("t1_len",   32'(ip_len), 32'd16);
        check("t1_proto", 32'(ip_protocol), 32'd17);
        check("t1_src",   ip_src_ip, 32'hC0A8_0103);
        check("t1_nlast", 32'(last_pos.size()), 32'd1);
        check("t1_lastpos", 32'(first_last()), 32'd15);
        check("t1_lat",   32'(lat_bad()), 32'd0);
        check("t1_err",   32'(err_cnt), 32'd0);

        // 8-byte payload inside a 46-byte padded MAC payload
        clear_mon();
        mk_frame(16'd28, 32'hC0A8_0102, 8, 18, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t2_count", 32'(out_q.size()), 32'd8);
        check("t2_data",  32'(bad_bytes(8, 0)), 32'd0);
        check("t2_lastpos", 32'(first_last()), 32'd7);
        check("t2_len",   32'(ip_len), 32'd8);
        check("t2_drop",  32'(drop_cnt), 32'd0);

        // Empty payload: accepted, nothing forwarded, not a drop
        clear_mon();
        mk_frame(16'd20, 32'hC0A8_0102, 0, 26, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t0_count", 32'(out_q.size()), 32'd0);
        check("t0_len",   32'(ip_len), 32'd0);
        check("t0_drop",  32'(drop_cnt), 32'd0);

        // Bad checksum, then foreign destination
        clear_mon();
        mk_frame(16'd28, 32'hC0A8_0102, 8, 18, 0, 1'b1);
        send_tx(tx.size(), 0, 1'b1);
        mk_frame(16'd28, 32'h0A00_0009, 8, 18, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t3_count", 32'(out_q.size()), 32'd0);
        check("t3_drop",  32'(drop_cnt), 32'd2);
        check("t3_len_hold", 32'(ip_len), 32'd0);

        // Reprogram local IP and resend; then broadcast destination
        local_ip = 32'h0A00_0009;
        local_ip_valid = 1'b1;
        @(posedge clk);
        #1;
        local_ip_valid = 1'b0;
        clear_mon();
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t4_count", 32'(out_q.size()), 32'd8);
        check("t4_drop",  32'(drop_cnt), 32'd2);
        clear_mon();
        mk_frame(16'd36, 32'hFFFF_FFFF, 16, 0, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t4_bcast", 32'(out_q.size()), 32'd16);

        // Truncated: total_length 100, frame ends after 30 payload bytes
        clear_mon();
        mk_frame(16'd100, 32'hFFFF_FFFF, 30, 0, 1, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t5_count", 32'(out_q.size()), 32'd30);
        check("t5_data",  32'(bad_bytes(30, 1)), 32'd0);
        check("t5_lastpos", 32'(first_last()), 32'd29);
        check("t5_errcnt", 32'(err_cnt), 32'd1);
        check("t5_errpos", 32'(err_at), 32'd29);
        check("t5_len",   32'(ip_len), 32'd80);

        // Valid gaps in header and payload
        clear_mon();
        mk_frame(16'd36, 32'hFFFF_FFFF, 16, 0, 0, 1'b0);
        send_tx(tx.size(), 1, 1'b1);
        drain();
        check("t6_count", 32'(out_q.size()), 32'd16);
        check("t6_data",  32'(bad_bytes(16, 0)), 32'd0);
        check("t6_lat",   32'(lat_bad()), 32'd0);
        check("t6_lastpos", 32'(first_last()), 32'd15);

        // Reset in the middle of a payload
        clear_mon();
        mk_frame(16'd36, 32'hFFFF_FFFF, 16, 0, 0, 1'b0);
        send_tx(25, 0, 1'b0);
        check("t7_pre_valid", 32'(ip_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t7_valid", 32'(ip_valid), 32'd0);
        check("t7_len",   32'(ip_len), 32'd0);
        check("t7_drop",  32'(drop_cnt), 32'd0);
        check("t7_proto", 32'(ip_protocol), 32'd0);
        drain();

        // Reset restores the default local IP
        clear_mon();
        mk_frame(16'd36, 32'hC0A8_0102, 16, 0, 0, 1'b0);
        send_tx(tx.size(), 0, 1'b1);
        drain();
        check("t8_count", 32'(out_q.size()), 32'd16);
        check("t8_drop",  32'(drop_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
